// File: rtl/s2p_frame_ctrl_if.sv
// Control and status bundle between a frame requester and the serial-to-parallel
// frame controller.
interface s2p_frame_ctrl_if #(
  parameter int PERIOD_W = 16
);
  logic                en;
  logic                start;
  logic                cont;
  logic [1:0]          ch_num;
  logic [PERIOD_W-1:0] frame_period;
  logic                err_clr;
  logic                data_valid;
  logic [3:0]          bit_cnt;
  logic [1:0]          ch_idx;
  logic                word_strobe;
  logic                frame_done;
  logic                busy;
  logic                overrun_err;

  modport master (
    output en, start, cont, ch_num, frame_period, err_clr,
    input  data_valid, bit_cnt, ch_idx, word_strobe, frame_done, busy, overrun_err
  );

  modport slave (
    input  en, start, cont, ch_num, frame_period, err_clr,
    output data_valid, bit_cnt, ch_idx, word_strobe, frame_done, busy, overrun_err
  );
endinterface

// File: rtl/s2p_frame_ctrl.sv
// Frame controller for a multi-channel serial ADC deserialiser: generates the
// active-low shift window, bit/channel indices, word strobes and frame pacing.
module s2p_frame_ctrl #(
  parameter int BITS_ADC   = 12,
  parameter int GAP_CYCLES = 2,
  parameter int PERIOD_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  s2p_frame_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, GAP} state_t;

  localparam logic [3:0] LAST_BIT = 4'(BITS_ADC - 1);
  localparam logic [3:0] LAST_GAP = 4'(GAP_CYCLES - 1);

  state_t              state_q, state_d;
  logic [3:0]          bit_cnt_q, bit_cnt_d;
  logic [1:0]          ch_idx_q, ch_idx_d;
  logic [1:0]          ch_lat_q, ch_lat_d;
  logic [3:0]          gap_cnt_q, gap_cnt_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                data_valid_q, data_valid_d;
  logic                word_strobe_q, word_strobe_d;
  logic                frame_done_q, frame_done_d;
  logic                busy_q, busy_d;
  logic                overrun_q, overrun_d;
  logic                set_err;

  // elapsed = cycles since frame start including the current one; the next
  // frame is due once elapsed reaches frame_period (period 0 is always due).
  logic [PERIOD_W:0]   elapsed;
  logic                due;
  logic                late;

  assign elapsed = {1'b0, period_q} + {{PERIOD_W{1'b0}}, 1'b1};
  assign due     = ({1'b0, bus.frame_period} <= elapsed);
  assign late    = ({1'b0, bus.frame_period} <  elapsed);

  always_comb begin
    state_d   = state_q;
    ch_lat_d  = ch_lat_q;
    bit_cnt_d = '0;
    ch_idx_d  = '0;
    gap_cnt_d = '0;
    period_d  = (&period_q) ? period_q : period_q + 1'b1;
    set_err   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.en && (bus.start || bus.cont)) begin
          state_d  = SHIFT;
          ch_lat_d = bus.ch_num;
          period_d = '0;
        end
      end
      WAIT: begin
        if (!bus.en || !bus.cont) begin
          state_d = IDLE;
        end else if (due) begin
          state_d  = SHIFT;
          ch_lat_d = bus.ch_num;
          period_d = '0;
        end
      end
      SHIFT: begin
        if (bit_cnt_q == LAST_BIT) begin
          if (ch_idx_q == ch_lat_q) begin
            state_d = GAP;
          end else begin
            ch_idx_d = 2'(ch_idx_q + 2'd1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
          ch_idx_d  = ch_idx_q;
        end
      end
      GAP: begin
        if (gap_cnt_q == LAST_GAP) begin
          if (bus.en && bus.cont) begin
            // A period no longer than the frame restarts immediately; shorter is an overrun.
            if (due) begin
              state_d  = SHIFT;
              ch_lat_d = bus.ch_num;
              period_d = '0;
              set_err  = late;
            end else begin
              state_d = WAIT;
            end
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    data_valid_d  = (state_d != SHIFT);
    word_strobe_d = (state_d == SHIFT) && (bit_cnt_d == LAST_BIT);
    frame_done_d  = (state_d == GAP) && (gap_cnt_d == LAST_GAP);
    busy_d        = (state_d == SHIFT) || (state_d == GAP);
    overrun_d     = set_err | (overrun_q & ~bus.err_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      ch_idx_q      <= '0;
      ch_lat_q      <= '0;
      gap_cnt_q     <= '0;
      period_q      <= '0;
      data_valid_q  <= 1'b1;
      word_strobe_q <= 1'b0;
      frame_done_q  <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      ch_idx_q      <= ch_idx_d;
      ch_lat_q      <= ch_lat_d;
      gap_cnt_q     <= gap_cnt_d;
      period_q      <= period_d;
      data_valid_q  <= data_valid_d;
      word_strobe_q <= word_strobe_d;
      frame_done_q  <= frame_done_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
    end
  end

  assign bus.data_valid  = data_valid_q;
  assign bus.bit_cnt     = bit_cnt_q;
  assign bus.ch_idx      = ch_idx_q;
  assign bus.word_strobe = word_strobe_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.busy        = busy_q;
  assign bus.overrun_err = overrun_q;

endmodule
